// File: rtl/led_scan_ctrl.sv
// HUB75-style LED panel row scanner: shifts 64 columns per row pair,
// latches, then displays each row for ON_CYCLES with frame/subframe counters.
module led_scan_ctrl #(
  parameter int ON_CYCLES = 64,
  parameter int SUBFRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [5:0]  x,
  output logic [4:0]  row,
  output logic [12:0] frame,
  output logic [7:0]  subframe,
  input  logic [2:0]  rgb_top,
  input  logic [2:0]  rgb_bot,
  output logic [2:0]  panel_rgb0,
  output logic [2:0]  panel_rgb1,
  output logic        panel_sclk,
  output logic        panel_latch,
  output logic        panel_oe_n,
  output logic [4:0]  panel_addr,
  output logic        frame_start
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SHIFT = 3'd1;
  localparam logic [2:0] BLANK = 3'd2;
  localparam logic [2:0] LATCH = 3'd3;
  localparam logic [2:0] ON    = 3'd4;

  localparam logic [15:0] ON_LAST  = 16'(ON_CYCLES - 1);
  localparam logic [7:0]  SUB_LAST = 8'(SUBFRAMES - 1);

  logic [2:0]  state, state_n;
  logic        phase, phase_n;
  logic [5:0]  x_n;
  logic [15:0] cnt, cnt_n;
  logic        last_on;
  logic [4:0]  row_n;
  logic [7:0]  sub_n;
  logic [12:0] frame_n;

  always_comb begin
    state_n = state;
    phase_n = phase;
    x_n     = x;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (enable) state_n = SHIFT;
      end
      SHIFT: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          if (x == 6'd63) begin
            x_n     = 6'd0;
            state_n = BLANK;
          end else begin
            x_n = x + 6'd1;
          end
        end
      end
      BLANK: state_n = LATCH;
      LATCH: begin
        state_n = ON;
        cnt_n   = 16'd0;
      end
      ON: begin
        if (cnt == ON_LAST) begin
          state_n = enable ? SHIFT : IDLE;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Counters roll over only on the final display cycle of a row.
  always_comb begin
    last_on = (state == ON) && (cnt == ON_LAST);
    row_n   = row;
    sub_n   = subframe;
    frame_n = frame;
    if (last_on) begin
      row_n = row + 5'd1;
      if (row == 5'd31) begin
        if (subframe == SUB_LAST) begin
          sub_n   = 8'd0;
          frame_n = frame + 13'd1;
        end else begin
          sub_n = subframe + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= 1'b0;
      cnt         <= 16'd0;
      x           <= 6'd0;
      row         <= 5'd0;
      subframe    <= 8'd0;
      frame       <= 13'd0;
      panel_addr  <= 5'd0;
      panel_rgb0  <= 3'd0;
      panel_rgb1  <= 3'd0;
      panel_sclk  <= 1'b0;
      panel_latch <= 1'b0;
      panel_oe_n  <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      cnt      <= cnt_n;
      x        <= x_n;
      row      <= row_n;
      subframe <= sub_n;
      frame    <= frame_n;
      if (state == SHIFT && !phase) begin
        panel_rgb0 <= rgb_top;
        panel_rgb1 <= rgb_bot;
      end
      if (state == BLANK) panel_addr <= row;
      // Strobes are decoded from the next state so they align with it.
      panel_sclk  <= (state_n == SHIFT) && phase_n;
      panel_latch <= (state_n == LATCH);
      panel_oe_n  <= (state_n != ON);
      frame_start <= (state_n == SHIFT) && (state != SHIFT)
                     && (row_n == 5'd0) && (sub_n == 8'd0);
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed self-checking bench for led_scan_ctrl
// (ON_CYCLES=64, SUBFRAMES=2).
module tb_led_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [5:0]  x;
  logic [4:0]  row;
  logic [12:0] frame;
  logic [7:0]  subframe;
  logic [2:0]  rgb_top, rgb_bot;
  logic [2:0]  panel_rgb0, panel_rgb1;
  logic        panel_sclk, panel_latch, panel_oe_n;
  logic [4:0]  panel_addr;
  logic        frame_start;

  int checks = 0;
  int fails  = 0;
  int cyc = 0;
  int rises, lat, oel, fs, derr, base;
  logic prev_sclk = 1'b0;
  logic found;

  always #5 clk = ~clk;

  // Painters echo column; bottom inverted to expose swaps.
  assign rgb_top = x[2:0];
  assign rgb_bot = ~x[2:0];

  led_scan_ctrl #(.ON_CYCLES(64), .SUBFRAMES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .x(x), .row(row), .frame(frame), .subframe(subframe),
    .rgb_top(rgb_top), .rgb_bot(rgb_bot),
    .panel_rgb0(panel_rgb0), .panel_rgb1(panel_rgb1),
    .panel_sclk(panel_sclk), .panel_latch(panel_latch),
    .panel_oe_n(panel_oe_n), .panel_addr(panel_addr),
    .frame_start(frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr;
    rises = 0; lat = 0; oel = 0; derr = 0;
  endtask

  task automatic tick;
    logic [5:0] c;
    @(negedge clk);
    cyc++;
    if (panel_sclk && !prev_sclk) begin
      c = 6'(base + rises);
      rises++;
      if (panel_rgb0 !== c[2:0]) derr++;
      if (panel_rgb1 !== ~c[2:0]) derr++;
      if (x !== c) derr++;
    end
    prev_sclk = panel_sclk;
    if (panel_latch) lat++;
    if (!panel_oe_n) oel++;
    if (frame_start) fs++;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    base = 0; fs = 0;
    clr();
    repeat (3) @(negedge clk);
    check("rst_oe_n", panel_oe_n, 1);
    check("rst_sclk", panel_sclk, 0);
    check("rst_latch", panel_latch, 0);
    check("rst_x", x, 0);
    check("rst_row", row, 0);
    check("rst_frame", frame, 0);
    check("rst_sub", subframe, 0);
    check("rst_addr", panel_addr, 0);
    check("rst_fs", frame_start, 0);
    check("rst_rgb", {panel_rgb0, panel_rgb1}, 0);

    reset = 1'b0;
    repeat (3) tick();
    check("idle_oe_n", panel_oe_n, 1);
    check("idle_sclk", panel_sclk, 0);
    check("idle_x", x, 0);

    enable = 1'b1;
    cyc = 0; fs = 0;
    clr();
    tick();
    check("first_fs", frame_start, 1);
    check("first_sclk", panel_sclk, 0);
    repeat (193) tick();
    check("row_sclk_rises", rises, 64);
    check("row_latches", lat, 1);
    check("row_oe_low", oel, 64);
    check("row_data", derr, 0);
    tick();
    check("row1_row", row, 1);
    check("row1_addr", panel_addr, 0);
    check("row1_fs", frame_start, 0);
    check("row1_x", x, 0);

    while (cyc < 32 * 194 + 1) tick();
    check("sub1_sub", subframe, 1);
    check("sub1_row", row, 0);
    check("sub1_fs_count", fs, 1);
    while (cyc < 64 * 194 + 1) tick();
    check("frame1_fs", frame_start, 1);
    check("frame1_frame", frame, 1);
    check("frame1_sub", subframe, 0);
    check("frame1_row", row, 0);
    check("frame1_fs_count", fs, 2);

    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (x == 6'd10 && !panel_sclk) found = 1'b1;
    end
    check("wait_x10", found, 1);
    enable = 1'b0;
    base = 10;
    clr();
    repeat (200) tick();
    check("drop_rises", rises, 54);
    check("drop_latches", lat, 1);
    check("drop_oe_low", oel, 64);
    check("drop_data", derr, 0);
    check("drop_idle_oe", panel_oe_n, 1);
    check("drop_idle_sclk", panel_sclk, 0);
    check("drop_row", row, 1);
    check("drop_addr", panel_addr, 0);
    enable = 1'b1;
    tick();
    check("resume_x", x, 0);
    check("resume_row", row, 1);
    check("resume_fs", frame_start, 0);
    tick();
    check("resume_sclk", panel_sclk, 1);

    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (!panel_oe_n) found = 1'b1;
    end
    check("wait_on", found, 1);
    check("pre_rst_frame", frame, 1);
    reset = 1'b1;
    #1;
    check("on_rst_oe_n", panel_oe_n, 1);
    check("on_rst_frame", frame, 0);
    check("on_rst_row", row, 0);
    check("on_rst_sub", subframe, 0);
    check("on_rst_addr", panel_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("rel_fs", frame_start, 1);
    check("rel_x", x, 0);
    check("rel_sclk", panel_sclk, 0);
    tick();
    check("rel_sclk_hi", panel_sclk, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 Parameter ON_CYCLES, default 64, display (OE active) cycles per row; legal range 1..65535.
REQ-002 Parameter SUBFRAMES, default 8, subframes per frame; legal range 1..256.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  run request; sampled at IDLE exit and at row end.
REQ-006 x  output  6  column presented to painters.
REQ-007 row  output  5  row pair; top painter y={0,row}, bottom painter y={1,row}.
REQ-008 frame  output  13  frame count to painters.
REQ-009 subframe  output  8  subframe count to painters.
REQ-010 rgb_top  input  3  {B,G,R} from top painter for (x, {0,row}).
REQ-011 rgb_bot  input  3  {B,G,R} from bottom painter for (x, {1,row}).
REQ-012 panel_rgb0  output  3  upper-half shift data.
REQ-013 panel_rgb1  output  3  lower-half shift data.
REQ-014 panel_sclk  output  1  panel shift clock.
REQ-015 panel_latch  output  1  panel latch strobe.
REQ-016 panel_oe_n  output  1  panel output enable, active-low.
REQ-017 panel_addr  output  5  displayed row address.
REQ-018 frame_start  output  1  one-cycle pulse at start of each frame.

Function
REQ-019 FSM states IDLE, SHIFT, BLANK, LATCH, ON; all outputs driven from registers, no combinational input-to-output path.
REQ-020 IDLE: panel_oe_n=1, panel_sclk=0, panel_latch=0; enable=1 -> SHIFT next cycle, else stay.
REQ-021 SHIFT: 128 cycles, two per column, x=0..63 ascending; phase 0: x presented, panel_sclk=0; phase 1: panel_sclk=1, same x.
REQ-022 panel_rgb0/panel_rgb1 load rgb_top/rgb_bot at end of phase 0; stable through phase 1 (data valid at sclk rising edge).
REQ-023 After x=63 phase 1 -> BLANK, x returns to 0.
REQ-024 BLANK: 1 cycle, panel_oe_n=1, panel_sclk=0 -> LATCH.
REQ-025 LATCH: 1 cycle, panel_latch=1, panel_oe_n=1; panel_addr loads row on LATCH entry -> ON.
REQ-026 ON: exactly ON_CYCLES cycles panel_oe_n=0; all other states panel_oe_n=1.
REQ-027 Last ON cycle advances counters: row+1; row 31->0 advances subframe; subframe SUBFRAMES-1->0 advances frame; frame wraps 8191->0.
REQ-028 After ON: enable=1 -> SHIFT, enable=0 -> IDLE; row period = 130+ON_CYCLES cycles.
REQ-029 enable deasserted mid-row does not abort; current row completes through ON, then IDLE.
REQ-030 frame_start=1 for first SHIFT cycle when row=0 and subframe=0, else 0.
REQ-031 row, subframe, frame, panel_addr change only per REQ-025/REQ-027; x only in SHIFT.

Reset
REQ-032 reset=1 forces immediately, regardless of state: IDLE, x=0, row=0, subframe=0, frame=0, panel_addr=0, panel_rgb0=panel_rgb1=0, panel_sclk=0, panel_latch=0, panel_oe_n=1, frame_start=0.
REQ-033 After reset release with enable=1: first SHIFT cycle one clock after release, frame_start=1 that cycle.

Verification
REQ-034 Reset, enable=1, ON_CYCLES=64: 64 sclk rising edges, 1 latch pulse, 64 oe_n-low cycles per 194-cycle row; panel_addr=0 after first latch.
REQ-035 Painter models echoing x: at each panel_sclk rising edge panel_rgb0 = x[2:0] of that column; top/bottom swapped data detected.
REQ-036 SUBFRAMES=2: after 64 rows frame=1, subframe=0, row=0; frame_start pulses every 64*194 cycles.
REQ-037 Drop enable at SHIFT x=10: row finishes (latch, 64 ON cycles), then IDLE with oe_n=1; re-enable resumes at row+1.
REQ-038 Reset asserted during ON: same cycle oe_n=1, all counters 0; frame preset near 8191 wraps to 0 without glitch.
